apb_master: RTL and testbench

Bridge from a simple valid/ready command interface to the APB bus that the communication bench exercises. It accepts one read or write request at a time and runs the APB SETUP/ACCESS sequence towards the one-hot selected completer. It returns read data and an error flag as a single-cycle response. A wait-state timeout prevents a hung completer from locking the bus.

---
 rtl/apb_master.sv | 83 ++++++++
 tb/tb_apb_master.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: valid/ready command to APB bridge with one-hot select check and wait-state timeout
module apb_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  main_clk,
  input  logic                  main_rsn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [SEL_WIDTH-1:0]  req_sel,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [SEL_WIDTH-1:0]  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic last_wait;
  assign req_ready = (state == IDLE) && !main_rsn;
  assign last_wait = wait_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge main_clk or posedge main_rsn)
    if (main_rsn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          pwrite <= req_write;
          paddr  <= req_addr;
          pwdata <= req_wdata;
          if ($onehot(req_sel)) begin
            state    <= SETUP;
            psel     <= req_sel;
            wait_cnt <= '0;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: if (pready || last_wait) begin
          state     <= RESP;
          psel      <= '0;
          penable   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= (pready && !pwrite) ? prdata : '0;
          rsp_err   <= pready ? pslverr : 1'b1;
          wait_cnt  <= pready ? wait_cnt : wait_cnt + 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed requests against a reactive completer, checked every cycle against a timeline model
module tb_apb_master;
  localparam int DW = 32, AW = 16, SW = 4, TO = 4, MAXC = 1000;
  logic main_clk = 1'b0, main_rsn = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_sel = '0;
  logic rsp_valid, rsp_err, penable, pwrite, pready, pslverr;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic [SW-1:0] psel;
  logic [AW-1:0] paddr;
  int cyc = 0, passed = 0, total = 0, wcnt = 0, c_waits = 0;
  logic c_err = 1'b0, stop = 1'b0;
  logic [DW-1:0] c_rdata = '0;
  logic [SW-1:0] e_psel[MAXC];
  logic e_pen[MAXC], e_rv[MAXC], e_rdy[MAXC], e_pw[MAXC], e_err[MAXC];
  logic [AW-1:0] e_pa[MAXC];
  logic [DW-1:0] e_pd[MAXC], e_rd[MAXC];

  apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
    .main_clk(main_clk), .main_rsn(main_rsn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr));

  always #5 main_clk = ~main_clk;
  always @(posedge main_clk) cyc <= cyc + 1;

  // completer: ready after c_waits ACCESS cycles, junk data when not ready
  always @(posedge main_clk) wcnt <= (|psel && penable) ? wcnt + 1 : 0;
  assign pready  = (|psel) && penable && (wcnt >= c_waits);
  assign prdata  = pready ? c_rdata : 32'hBAD0BAD0;
  assign pslverr = pready && c_err;

  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, e);
  endfunction

  function automatic void model_clear(input int from);
    for (int k = from; k < MAXC; k++) begin
      e_psel[k] = '0; e_pen[k] = 0; e_rv[k] = 0; e_rdy[k] = 1; e_pw[k] = 0;
      e_err[k] = 0; e_pa[k] = '0; e_pd[k] = '0; e_rd[k] = '0;
    end
  endfunction

  // timeline of one transfer accepted at the edge ending period c
  function automatic void model_accept(input int c, input logic w, input logic [AW-1:0] a,
      input logic [DW-1:0] d, input logic [SW-1:0] s, input int waits, input logic perr,
      input logic [DW-1:0] rd);
    int r, acc_cycles;
    logic err;
    logic [DW-1:0] data;
    if ($countones(s) != 1) begin
      r = c + 1; err = 1; data = '0;
    end else begin
      acc_cycles = (waits + 1 <= TO) ? waits + 1 : TO;
      e_psel[c+1] = s;
      for (int k = c + 2; k <= c + 1 + acc_cycles; k++) begin e_psel[k] = s; e_pen[k] = 1; end
      r = c + 2 + acc_cycles;
      if (waits + 1 <= TO) begin err = perr; data = w ? '0 : rd; end
      else begin err = 1; data = '0; end
    end
    for (int k = c + 1; k <= r; k++) e_rdy[k] = 0;
    e_rv[r] = 1;
    for (int k = c + 1; k < MAXC; k++) begin e_pw[k] = w; e_pa[k] = a; e_pd[k] = d; end
    for (int k = r; k < MAXC; k++) begin e_err[k] = err; e_rd[k] = data; end
  endfunction

  always @(negedge main_clk)
    if (!main_rsn && !stop && cyc < MAXC) begin
      chk("psel", 64'(psel), 64'(e_psel[cyc]));
      chk("penable", 64'(penable), 64'(e_pen[cyc]));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv[cyc]));
      chk("req_ready", 64'(req_ready), 64'(e_rdy[cyc]));
      chk("pwrite", 64'(pwrite), 64'(e_pw[cyc]));
      chk("paddr", 64'(paddr), 64'(e_pa[cyc]));
      chk("pwdata", 64'(pwdata), 64'(e_pd[cyc]));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd[cyc]));
      chk("rsp_err", 64'(rsp_err), 64'(e_err[cyc]));
    end

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
      input logic [SW-1:0] s, input int waits, input logic perr, input logic [DW-1:0] rd,
      output int acc);
    @(negedge main_clk);
    c_waits = waits; c_err = perr; c_rdata = rd;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_sel = s;
    acc = cyc;
    model_accept(acc, w, a, d, s, waits, perr, rd);
    @(negedge main_clk);
    req_valid = 0;
  endtask

  task automatic req(input string n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
      input logic [SW-1:0] s, input int waits, input logic perr, input logic [DW-1:0] rd,
      input int exp_lat, input logic exp_err, input logic [DW-1:0] exp_rd);
    int acc;
    logic found;
    found = 0;
    drive(w, a, d, s, waits, perr, rd, acc);
    for (int i = 0; i < 40 && !found; i++)
      if (rsp_valid) found = 1;
      else @(negedge main_clk);
    chk({n, "_rsp_seen"}, 64'(found), 64'd1);
    if (found) begin
      chk({n, "_latency"}, 64'(cyc - acc), 64'(exp_lat));
      chk({n, "_err"}, 64'(rsp_err), 64'(exp_err));
      chk({n, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc;
    model_clear(0);
    repeat (2) @(negedge main_clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    #2 main_rsn = 0;
    #1 chk("release_ready", 64'(req_ready), 64'd1);
    req("write", 1, 16'h0010, 32'hDEADBEEF, 4'b0001, 0, 0, 32'h0, 3, 0, 32'h0);
    chk("write_paddr", 64'(paddr), 64'h10);
    chk("write_pwdata", 64'(pwdata), 64'hDEADBEEF);
    chk("write_pwrite", 64'(pwrite), 64'd1);
    req("read_wait2", 0, 16'h0024, 32'h0, 4'b0100, 2, 0, 32'h12345678, 5, 0, 32'h12345678);
    req("read_slverr", 0, 16'h0030, 32'h0, 4'b0010, 0, 1, 32'h0, 3, 1, 32'h0);
    req("write_slverr", 1, 16'h0040, 32'h55AA55AA, 4'b1000, 1, 1, 32'h99, 4, 1, 32'h0);
    req("timeout", 0, 16'h0050, 32'h0, 4'b0001, 100, 0, 32'h77, 6, 1, 32'h0);
    req("ready_at_limit", 0, 16'h0054, 32'h0, 4'b0010, 3, 0, 32'hA5A5A5A5, 6, 0, 32'hA5A5A5A5);
    req("sel_none", 1, 16'h0060, 32'h1, 4'b0000, 0, 0, 32'h0, 1, 1, 32'h0);
    req("sel_two", 0, 16'h0064, 32'h0, 4'b0011, 0, 0, 32'h1, 1, 1, 32'h0);
    drive(0, 16'h0068, 32'h0, 4'b0100, 100, 0, 32'h5, acc);
    repeat (2) @(negedge main_clk);
    #2 main_rsn = 1;
    #1;
    chk("midrst_psel", 64'(psel), 64'd0);
    chk("midrst_penable", 64'(penable), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    model_clear(cyc);
    repeat (3) @(negedge main_clk);
    #2 main_rsn = 0;
    #1 chk("midrst_release_ready", 64'(req_ready), 64'd1);
    req("post_reset_write", 1, 16'h0070, 32'h0BADCAFE, 4'b0100, 0, 0, 32'h0, 3, 0, 32'h0);
    repeat (3) @(negedge main_clk);
    stop = 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
